// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch sequencer.
// Issues fetch commands to the ITCM, buffers one returned word and hands it to
// the EXU over a valid/ready handshake. Flushes kill any in-flight fetch and
// redirect the next fetch to ifu_i_pcnxt.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   ifu_i_pcnxt, ifu_i_flush        next PC / redirect request from PC generator
//   ifu_o_cmd_*, ifu_i_cmd_ready    fetch command channel
//   ifu_i_rsp_*, ifu_o_rsp_ready    fetch response channel
//   ifu_o_valid, ifu_i_exu_ready    instruction handshake to EXU
//   ifu_o_instr/pc/rv32/bus_err     buffered instruction and attributes
//   ifu_o_init_use                  one-cycle pulse in BOOT after reset
module ifu_fetch #(
    parameter int unsigned              PC_SIZE    = 32,
    parameter int unsigned              INSTR_SIZE = 32,
    parameter logic [PC_SIZE-1:0]       RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_SIZE-1:0]    ifu_i_pcnxt,
    input  logic                  ifu_i_flush,
    output logic                  ifu_o_cmd_valid,
    input  logic                  ifu_i_cmd_ready,
    output logic [PC_SIZE-1:0]    ifu_o_cmd_addr,
    input  logic                  ifu_i_rsp_valid,
    output logic                  ifu_o_rsp_ready,
    input  logic [INSTR_SIZE-1:0] ifu_i_rsp_rdata,
    input  logic                  ifu_i_rsp_err,
    output logic                  ifu_o_valid,
    input  logic                  ifu_i_exu_ready,
    output logic [INSTR_SIZE-1:0] ifu_o_instr,
    output logic [PC_SIZE-1:0]    ifu_o_pc,
    output logic                  ifu_o_rv32,
    output logic                  ifu_o_bus_err,
    output logic                  ifu_o_init_use
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e                  state_q;
    logic [PC_SIZE-1:0]      addr_q;
    logic                    kill_q;
    logic                    cmd_valid_q;
    logic                    rsp_ready_q;
    logic                    valid_q;
    logic [INSTR_SIZE-1:0]   instr_q;
    logic [PC_SIZE-1:0]      pc_q;
    logic                    rv32_q;
    logic                    bus_err_q;
    logic                    init_use_q;

    // Sequencer: handshake outputs are registered alongside the state they
    // belong to, so each is updated on the transition into/out of that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            addr_q      <= RESET_PC;
            kill_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            rv32_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            init_use_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q     <= ST_REQ;
                    addr_q      <= RESET_PC;
                    cmd_valid_q <= 1'b1;
                    init_use_q  <= 1'b0;
                end
                ST_REQ: begin
                    // An unaccepted command may still be retargeted.
                    if (ifu_i_flush) begin
                        addr_q <= ifu_i_pcnxt;
                    end
                    if (ifu_i_cmd_ready) begin
                        state_q     <= ST_WAIT;
                        kill_q      <= ifu_i_flush;
                        cmd_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (ifu_i_rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        if (kill_q || ifu_i_flush) begin
                            // Stale response: drop it and refetch.
                            state_q     <= ST_REQ;
                            kill_q      <= 1'b0;
                            cmd_valid_q <= 1'b1;
                            if (ifu_i_flush) begin
                                addr_q <= ifu_i_pcnxt;
                            end
                        end else begin
                            state_q   <= ST_HOLD;
                            valid_q   <= 1'b1;
                            instr_q   <= ifu_i_rsp_err ? '0 : ifu_i_rsp_rdata;
                            pc_q      <= addr_q;
                            bus_err_q <= ifu_i_rsp_err;
                            // Errored fetches are reported as 32-bit so the EXU
                            // advances by a full word.
                            rv32_q    <= ifu_i_rsp_err ? 1'b1
                                                       : (ifu_i_rsp_rdata[1:0] == 2'b11);
                        end
                    end else if (ifu_i_flush) begin
                        kill_q <= 1'b1;
                        addr_q <= ifu_i_pcnxt;
                    end
                end
                ST_HOLD: begin
                    // Flush and accept both leave for the PC generator's target.
                    if (ifu_i_flush || ifu_i_exu_ready) begin
                        state_q     <= ST_REQ;
                        addr_q      <= ifu_i_pcnxt;
                        valid_q     <= 1'b0;
                        cmd_valid_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ifu_o_cmd_valid = cmd_valid_q;
    assign ifu_o_cmd_addr  = addr_q;
    assign ifu_o_rsp_ready = rsp_ready_q;
    assign ifu_o_valid     = valid_q;
    assign ifu_o_instr     = instr_q;
    assign ifu_o_pc        = pc_q;
    assign ifu_o_rv32      = rv32_q;
    assign ifu_o_bus_err   = bus_err_q;
    assign ifu_o_init_use  = init_use_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed-vector bench for ifu_fetch.
module tb_ifu_fetch;

    localparam int unsigned PC_SIZE    = 32;
    localparam int unsigned INSTR_SIZE = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PC_SIZE-1:0]    pcnxt;
    logic                  flush;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [PC_SIZE-1:0]    cmd_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [INSTR_SIZE-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  o_valid;
    logic                  exu_ready;
    logic [INSTR_SIZE-1:0] instr;
    logic [PC_SIZE-1:0]    pc;
    logic                  rv32;
    logic                  bus_err;
    logic                  init_use;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifu_fetch #(
        .PC_SIZE   (PC_SIZE),
        .INSTR_SIZE(INSTR_SIZE),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_i_pcnxt    (pcnxt),
        .ifu_i_flush    (flush),
        .ifu_o_cmd_valid(cmd_valid),
        .ifu_i_cmd_ready(cmd_ready),
        .ifu_o_cmd_addr (cmd_addr),
        .ifu_i_rsp_valid(rsp_valid),
        .ifu_o_rsp_ready(rsp_ready),
        .ifu_i_rsp_rdata(rsp_rdata),
        .ifu_i_rsp_err  (rsp_err),
        .ifu_o_valid    (o_valid),
        .ifu_i_exu_ready(exu_ready),
        .ifu_o_instr    (instr),
        .ifu_o_pc       (pc),
        .ifu_o_rv32     (rv32),
        .ifu_o_bus_err  (bus_err),
        .ifu_o_init_use (init_use)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
        rsp_err = 1'b0; exu_ready = 1'b0; rsp_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pcnxt = '0; idle_inputs();
        step(); step();
        checks++; if ({cmd_valid, rsp_ready, o_valid, init_use} !== 4'b0001) begin
            errors++; $display("FAIL reset_ctl got=%b want=0001", {cmd_valid, rsp_ready, o_valid, init_use}); end
        checks++; if ({instr, pc, rv32, bus_err} !== 66'h0) begin
            errors++; $display("FAIL reset_buf instr=%h pc=%h rv32=%b err=%b want zeros", instr, pc, rv32, bus_err); end
        rst = 1'b0;
        // BOOT cycle after release
        checks++; if (init_use !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL boot_cycle init_use=%b cmd_valid=%b want 1/0", init_use, cmd_valid); end
        step();
        checks++; if (init_use !== 1'b0 || cmd_valid !== 1'b1 || cmd_addr !== 32'h0) begin
            errors++; $display("FAIL boot_req init_use=%b cmd_valid=%b addr=%h want 0/1/0", init_use, cmd_valid, cmd_addr); end
    endtask

    task automatic test_boot_fetch();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        checks++; if (rsp_ready !== 1'b1 || cmd_valid !== 1'b0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL boot_wait rsp_ready=%b cmd_valid=%b o_valid=%b want 1/0/0", rsp_ready, cmd_valid, o_valid); end
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_0013; step(); rsp_valid = 1'b0;
        checks++; if ({o_valid, rv32, bus_err} !== 3'b110 || instr !== 32'h13 || pc !== 32'h0) begin
            errors++; $display("FAIL boot_hold v/rv32/err=%b instr=%h pc=%h want 110/00000013/0", {o_valid, rv32, bus_err}, instr, pc); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (o_valid !== 1'b1 || instr !== 32'h13 || pc !== 32'h0 || cmd_valid !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] v=%b instr=%h pc=%h cmd_valid=%b want 1/13/0/0", i, o_valid, instr, pc, cmd_valid); end
        end
        exu_ready = 1'b1; pcnxt = 32'h4; step(); exu_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h4 || o_valid !== 1'b0) begin
            errors++; $display("FAIL bp_next cmd_valid=%b addr=%h o_valid=%b want 1/4/0", cmd_valid, cmd_addr, o_valid); end
    endtask

    task automatic test_compressed();
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h4) begin
                errors++; $display("FAIL cmd_stall[%0d] cmd_valid=%b addr=%h want 1/4", i, cmd_valid, cmd_addr); end
        end
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_4501; step(); rsp_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || rv32 !== 1'b0 || instr !== 32'h4501 || pc !== 32'h4) begin
            errors++; $display("FAIL compressed v=%b rv32=%b instr=%h pc=%h want 1/0/4501/4", o_valid, rv32, instr, pc); end
        exu_ready = 1'b1; pcnxt = 32'h8; step(); exu_ready = 1'b0;
    endtask

    task automatic test_flush_wait();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        flush = 1'b1; pcnxt = 32'h80; step(); flush = 1'b0;
        checks++; if (rsp_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL flushw_wait rsp_ready=%b o_valid=%b want 1/0", rsp_ready, o_valid); end
        rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF; step(); rsp_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || cmd_valid !== 1'b1 || cmd_addr !== 32'h80) begin
            errors++; $display("FAIL flushw_drop o_valid=%b cmd_valid=%b addr=%h want 0/1/80", o_valid, cmd_valid, cmd_addr); end
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_0093; step(); rsp_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || pc !== 32'h80 || instr !== 32'h93) begin
            errors++; $display("FAIL flushw_new v=%b pc=%h instr=%h want 1/80/93", o_valid, pc, instr); end
        exu_ready = 1'b1; pcnxt = 32'h84; step(); exu_ready = 1'b0;
        checks++; if (cmd_addr !== 32'h84 || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL flushw_seq addr=%h cmd_valid=%b want 84/1", cmd_addr, cmd_valid); end
    endtask

    task automatic test_flush_coincident();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h1111_1113; flush = 1'b1; pcnxt = 32'h100; step();
        rsp_valid = 1'b0; flush = 1'b0;
        checks++; if (o_valid !== 1'b0 || cmd_valid !== 1'b1 || cmd_addr !== 32'h100) begin
            errors++; $display("FAIL coin_rsp o_valid=%b cmd_valid=%b addr=%h want 0/1/100", o_valid, cmd_valid, cmd_addr); end
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_0013; step(); rsp_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || pc !== 32'h100) begin
            errors++; $display("FAIL coin_fetch v=%b pc=%h want 1/100", o_valid, pc); end
        flush = 1'b1; exu_ready = 1'b1; pcnxt = 32'h200; step(); flush = 1'b0; exu_ready = 1'b0;
        checks++; if (o_valid !== 1'b0 || cmd_valid !== 1'b1 || cmd_addr !== 32'h200) begin
            errors++; $display("FAIL coin_hold o_valid=%b cmd_valid=%b addr=%h want 0/1/200", o_valid, cmd_valid, cmd_addr); end
        // Flush on the very cycle the command is accepted: that fetch is killed.
        cmd_ready = 1'b1; flush = 1'b1; pcnxt = 32'h300; step(); cmd_ready = 1'b0; flush = 1'b0;
        checks++; if (rsp_ready !== 1'b1 || cmd_addr !== 32'h300) begin
            errors++; $display("FAIL coin_req rsp_ready=%b addr=%h want 1/300", rsp_ready, cmd_addr); end
        rsp_valid = 1'b1; rsp_rdata = 32'h0000_0013; step(); rsp_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || cmd_valid !== 1'b1 || cmd_addr !== 32'h300) begin
            errors++; $display("FAIL coin_kill o_valid=%b cmd_valid=%b addr=%h want 0/1/300", o_valid, cmd_valid, cmd_addr); end
    endtask

    task automatic test_bus_err_reset();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = 32'h1234_5678; step();
        rsp_valid = 1'b0; rsp_err = 1'b0;
        checks++; if ({o_valid, bus_err, rv32} !== 3'b111 || instr !== 32'h0 || pc !== 32'h300) begin
            errors++; $display("FAIL bus_err v/err/rv32=%b instr=%h pc=%h want 111/0/300", {o_valid, bus_err, rv32}, instr, pc); end
        exu_ready = 1'b1; pcnxt = 32'h304; step(); exu_ready = 1'b0;
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        rst = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h0000_0013; step();
        rsp_valid = 1'b0;
        checks++; if ({cmd_valid, rsp_ready, o_valid, init_use, rv32, bus_err} !== 6'b000100 || instr !== 32'h0 || pc !== 32'h0) begin
            errors++; $display("FAIL rst_wait ctl=%b instr=%h pc=%h want 000100/0/0", {cmd_valid, rsp_ready, o_valid, init_use, rv32, bus_err}, instr, pc); end
        rst = 1'b0;
        step();
        checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 32'h0 || init_use !== 1'b0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL rst_reboot cmd_valid=%b addr=%h init_use=%b o_valid=%b want 1/0/0/0", cmd_valid, cmd_addr, init_use, o_valid); end
    endtask

    initial begin
        test_reset();
        test_boot_fetch();
        test_backpressure();
        test_compressed();
        test_flush_wait();
        test_flush_coincident();
        test_bus_err_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Fetch sequencer for the IFU. Consumes the next-PC value from the PC generator and issues single-outstanding instruction fetches to the ITCM over a valid/ready command/response bus.
- Buffers one returned instruction and presents it to the EXU with a valid/ready handshake. Its accept strobe also serves as the PC register load enable.
- Handles flushes (branch/jump, exception, interrupt) by killing in-flight fetches and redirecting.

Parameters:
- PC_SIZE, 32, width of PC and fetch address.
- INSTR_SIZE, 32, width of fetched word.
- RESET_PC, 0, address of the first fetch after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ifu_i_pcnxt  in  PC_SIZE  next PC from PC generator; already equals the flush target when a flush is active.
- ifu_i_flush  in  1  flush request (bjp | excp | irq).
- ifu_o_cmd_valid  out  1  fetch command valid.
- ifu_i_cmd_ready  in  1  ITCM accepts command.
- ifu_o_cmd_addr  out  PC_SIZE  fetch address.
- ifu_i_rsp_valid  in  1  fetch response valid.
- ifu_o_rsp_ready  out  1  IFU accepts response.
- ifu_i_rsp_rdata  in  INSTR_SIZE  fetched word.
- ifu_i_rsp_err  in  1  bus error on fetch.
- ifu_o_valid  out  1  instruction valid to EXU; PC-register load enable when ANDed with exu_ready.
- ifu_i_exu_ready  in  1  EXU accepts instruction.
- ifu_o_instr  out  INSTR_SIZE  buffered instruction.
- ifu_o_pc  out  PC_SIZE  address of the buffered instruction.
- ifu_o_rv32  out  1  1 = 32-bit encoding (instr[1:0]==2'b11), 0 = 16-bit.
- ifu_o_bus_err  out  1  buffered instruction carries a fetch bus error.
- ifu_o_init_use  out  1  high for exactly the one BOOT cycle after reset release.

Behaviour:
- Reset (sync, any state):
  - state = BOOT, addr_r = RESET_PC, kill_r = 0.
  - Outputs: cmd_valid = 0, rsp_ready = 0, o_valid = 0, instr = 0, pc = 0, rv32 = 0, bus_err = 0, init_use = 1.
- Only one fetch outstanding at a time. cmd_addr = addr_r.
- BOOT:
  - init_use = 1; no command issued.
  - Next cycle -> REQ with addr_r = RESET_PC.
- REQ:
  - cmd_valid = 1.
  - cmd_valid & cmd_ready -> WAIT; kill_r = flush.
  - If flush that cycle, addr_r <= pcnxt regardless of cmd_ready. A not-yet-accepted command may change address on flush.
- WAIT:
  - rsp_ready = 1. flush without rsp_valid -> kill_r <= 1, addr_r <= pcnxt.
  - rsp_valid with (kill_r | flush): discard response, kill_r <= 0, -> REQ. If flush, addr_r <= pcnxt.
  - rsp_valid otherwise, -> HOLD, capturing:
    - instr <= (rsp_err ? 0 : rdata)
    - pc <= addr_r
    - bus_err <= rsp_err
    - rv32 <= (rsp_err ? 1 : rdata[1:0]==2'b11)
- HOLD:
  - o_valid = 1. instr/pc/rv32/bus_err stable until accepted.
  - flush (priority over exu_ready): drop buffer, addr_r <= pcnxt, -> REQ.
  - exu_ready: addr_r <= pcnxt, -> REQ.
  - Else stay in HOLD.
- o_valid never asserts for a killed fetch. Minimum fetch-to-valid latency: cmd accept at cycle N, rsp at N+1, o_valid at N+2.
- Back-to-back throughput: one instruction per 3 cycles (REQ, WAIT, HOLD). Prefetch is out of scope.
- ifu_o_pc always equals the address sent on the command that produced the buffered word.
- Addresses wrap modulo 2^PC_SIZE; no alignment check (misalignment is handled by EXU).
- Reset during WAIT: the response is dropped (rsp_ready = 0 in BOOT). The ITCM is reset in the same domain.

Test Plan:
- Boot fetch: rst high 2 cycles, then low. init_use = 1 for one cycle. Next: cmd_valid = 1, addr 0x0. cmd_ready = 1, then rsp rdata 0x00000013 -> o_valid = 1, instr 0x13, pc 0x0, rv32 1.
- Backpressure: HOLD with exu_ready = 0 for 3 cycles -> o_valid/instr/pc stable, cmd_valid = 0. exu_ready = 1 with pcnxt 0x4 -> next cycle cmd addr 0x4.
- Compressed: rsp rdata 0x00004501 -> rv32 0, instr 0x4501. With cmd_ready held low 2 cycles in REQ, cmd_addr stays constant.
- Flush in WAIT: flush with pcnxt 0x80 before the response arrives. rsp 0xDEADBEEF one cycle later -> discarded, o_valid stays 0. Next cmd addr 0x80. Its response delivered with pc 0x80.
- Flush coincident: rsp_valid and flush (pcnxt 0x100) in the same cycle; also flush and exu_ready together in HOLD -> both discard. Next cmd addr 0x100, no o_valid for the old word.
- Bus error and reset: rsp_err = 1 -> o_valid with bus_err 1, instr 0, rv32 1. Separately, rst asserted in WAIT -> all outputs at reset values the next cycle, BOOT then cmd addr RESET_PC.
